// File: rtl/planta_envase_if.sv
// Sensor/actuator bus between the bottling controller (master) and the plant emulator (slave).
// The estado/pos/nivel/selada/estoque fields expose the plant's internal state for observation.
interface planta_envase_if #(
    parameter int POS_W = 4,
    parameter int LVL_W = 3,
    parameter int STK_W = 4
);
    logic             tick;
    logic             MOTOR;
    logic             EV;
    logic             VE;
    logic             ALARME;
    logic             repor;
    logic             PG;
    logic             CH;
    logic             RO;
    logic             CQ;
    logic             EB;
    logic             IR;
    logic             erro;
    logic [1:0]       estado;
    logic [POS_W-1:0] pos;
    logic [LVL_W-1:0] nivel;
    logic             selada;
    logic [STK_W-1:0] estoque;

    modport master (
        output tick, MOTOR, EV, VE, ALARME, repor,
        input  PG, CH, RO, CQ, EB, IR, erro,
        input  estado, pos, nivel, selada, estoque
    );

    modport slave (
        input  tick, MOTOR, EV, VE, ALARME, repor,
        output PG, CH, RO, CQ, EB, IR, erro,
        output estado, pos, nivel, selada, estoque
    );
endinterface

// File: rtl/planta_envase.sv
// Bottling plant emulator: models one bottle at a time moving along a belt, being filled,
// corked and checked, and drives the plant sensors back to the controller.
module planta_envase #(
    parameter int POS_W      = 4,
    parameter int FILL_POS   = 4,
    parameter int CORK_POS   = 8,
    parameter int QC_POS     = 12,
    parameter int EXIT_POS   = 15,
    parameter int FILL_TICKS = 5,
    parameter int LOAD_TICKS = 3,
    parameter int STOCK      = 12
) (
    input logic              clock,
    input logic              reset,
    planta_envase_if.slave   bus
);
    localparam int LVL_W = $clog2(FILL_TICKS + 1);
    localparam int STK_W = $clog2(STOCK + 1);
    localparam int CNT_W = $clog2(LOAD_TICKS + 1);

    localparam logic [1:0] VAZIO   = 2'd0;
    localparam logic [1:0] CARGA   = 2'd1;
    localparam logic [1:0] ESTEIRA = 2'd2;
    localparam logic [1:0] SAIDA   = 2'd3;

    logic [1:0]       estado_q, estado_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [LVL_W-1:0] nivel_q, nivel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STK_W-1:0] estoque_q, estoque_d;
    logic             selada_q, selada_d;
    logic             erro_q, erro_d;
    logic             ve_q;

    logic adv, ve_edge, carga_fim;
    logic pg, ch, ro;

    assign adv     = bus.tick && !bus.ALARME;
    assign ve_edge = bus.VE && !ve_q;

    assign pg = (estado_q == ESTEIRA) && (pos_q == POS_W'(FILL_POS));
    assign ro = (estado_q == ESTEIRA) && (pos_q == POS_W'(CORK_POS));
    assign ch = (estado_q == ESTEIRA) && (nivel_q == LVL_W'(FILL_TICKS));

    always_comb begin
        estado_d  = estado_q;
        pos_d     = pos_q;
        nivel_d   = nivel_q;
        cnt_d     = cnt_q;
        estoque_d = estoque_q;
        selada_d  = selada_q;
        erro_d    = erro_q;
        carga_fim = 1'b0;

        case (estado_q)
            VAZIO: begin
                if (adv && (estoque_q != '0)) begin
                    estado_d = CARGA;
                    cnt_d    = '0;
                end
            end
            CARGA: begin
                // Entering CARGA already counts as the first load tick.
                if (adv) begin
                    if (cnt_q == CNT_W'(LOAD_TICKS - 2)) begin
                        estado_d  = ESTEIRA;
                        pos_d     = '0;
                        nivel_d   = '0;
                        selada_d  = 1'b0;
                        carga_fim = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ESTEIRA: begin
                if (adv) begin
                    if (bus.MOTOR) begin
                        if (pos_q == POS_W'(EXIT_POS)) estado_d = SAIDA;
                        else                           pos_d    = pos_q + POS_W'(1);
                    end else if (bus.EV) begin
                        if (!pg)                                erro_d  = 1'b1;
                        else if (nivel_q < LVL_W'(FILL_TICKS)) nivel_d = nivel_q + LVL_W'(1);
                    end
                end
            end
            SAIDA: begin
                estado_d = VAZIO;
            end
            default: begin
                estado_d = VAZIO;
            end
        endcase

        // A cork is only legal on a full, unsealed bottle at the sealing station.
        if (ve_edge && !bus.ALARME) begin
            if (ro && ch && !selada_q) selada_d = 1'b1;
            else                       erro_d   = 1'b1;
        end

        if (carga_fim) estoque_d = estoque_q - STK_W'(1);
        if (bus.repor) estoque_d = carga_fim ? STK_W'(STOCK - 1) : STK_W'(STOCK);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= VAZIO;
            pos_q     <= '0;
            nivel_q   <= '0;
            cnt_q     <= '0;
            estoque_q <= STK_W'(STOCK);
            selada_q  <= 1'b0;
            erro_q    <= 1'b0;
            ve_q      <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            pos_q     <= pos_d;
            nivel_q   <= nivel_d;
            cnt_q     <= cnt_d;
            estoque_q <= estoque_d;
            selada_q  <= selada_d;
            erro_q    <= erro_d;
            ve_q      <= bus.VE;
        end
    end

    assign bus.PG      = pg;
    assign bus.RO      = ro;
    assign bus.CH      = ch;
    assign bus.CQ      = (estado_q == ESTEIRA) && (pos_q == POS_W'(QC_POS)) && ch && selada_q;
    assign bus.EB      = (estoque_q == '0);
    assign bus.IR      = (estado_q == SAIDA);
    assign bus.erro    = erro_q;
    assign bus.estado  = estado_q;
    assign bus.pos     = pos_q;
    assign bus.nivel   = nivel_q;
    assign bus.selada  = selada_q;
    assign bus.estoque = estoque_q;
endmodule

// File: tb/tb_planta_envase.sv
// Directed bench for planta_envase: one bottle through fill/seal/QC/exit, faults, alarm,
// magazine depletion and refill.
module tb_planta_envase;
    localparam logic [1:0] VAZIO   = 2'd0;
    localparam logic [1:0] CARGA   = 2'd1;
    localparam logic [1:0] ESTEIRA = 2'd2;
    localparam logic [1:0] SAIDA   = 2'd3;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    planta_envase_if bus ();

    planta_envase dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle_inputs();
        bus.tick   = 1'b1;
        bus.MOTOR  = 1'b0;
        bus.EV     = 1'b0;
        bus.VE     = 1'b0;
        bus.ALARME = 1'b0;
        bus.repor  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        checks++; if (bus.estado !== VAZIO) begin failures++; $display("FAIL rst_estado got=%0d exp=%0d", bus.estado, VAZIO); end
        checks++; if (bus.pos !== 4'd0) begin failures++; $display("FAIL rst_pos got=%0d exp=0", bus.pos); end
        checks++; if (bus.estoque !== 4'd12) begin failures++; $display("FAIL rst_estoque got=%0d exp=12", bus.estoque); end
        checks++; if ({bus.PG, bus.CH, bus.RO, bus.CQ, bus.EB, bus.IR, bus.erro} !== 7'b0) begin
            failures++; $display("FAIL rst_outputs got=%b exp=0000000", {bus.PG, bus.CH, bus.RO, bus.CQ, bus.EB, bus.IR, bus.erro}); end
        step(1);
        reset = 1'b0;
    endtask

    task automatic test_load();
        step(1);
        checks++; if (bus.estado !== CARGA) begin failures++; $display("FAIL load_carga got=%0d exp=%0d", bus.estado, CARGA); end
        step(2);
        checks++; if (bus.estado !== ESTEIRA) begin failures++; $display("FAIL load_esteira got=%0d exp=%0d", bus.estado, ESTEIRA); end
        checks++; if (bus.estoque !== 4'd11) begin failures++; $display("FAIL load_estoque got=%0d exp=11", bus.estoque); end
        checks++; if ({bus.PG, bus.RO, bus.pos} !== 6'd0) begin failures++; $display("FAIL load_pg_ro_pos got=%0d exp=0", {bus.PG, bus.RO, bus.pos}); end
    endtask

    task automatic test_fill();
        bus.MOTOR = 1'b1;
        step(4);
        bus.MOTOR = 1'b0;
        checks++; if (bus.pos !== 4'd4) begin failures++; $display("FAIL fill_pos got=%0d exp=4", bus.pos); end
        checks++; if (bus.PG !== 1'b1) begin failures++; $display("FAIL fill_pg got=%0d exp=1", bus.PG); end
        bus.EV = 1'b1;
        step(4);
        checks++; if ({bus.CH, bus.nivel} !== 4'd4) begin failures++; $display("FAIL fill_4 got=%0d exp=4", {bus.CH, bus.nivel}); end
        step(1);
        checks++; if (bus.CH !== 1'b1) begin failures++; $display("FAIL fill_ch got=%0d exp=1", bus.CH); end
        step(2);
        bus.EV = 1'b0;
        checks++; if (bus.nivel !== 3'd5) begin failures++; $display("FAIL fill_sat got=%0d exp=5", bus.nivel); end
        checks++; if (bus.erro !== 1'b0) begin failures++; $display("FAIL fill_erro got=%0d exp=0", bus.erro); end
    endtask

    task automatic test_seal();
        bus.MOTOR = 1'b1;
        step(4);
        bus.MOTOR = 1'b0;
        checks++; if ({bus.RO, bus.PG, bus.pos} !== 6'b10_1000) begin failures++; $display("FAIL seal_ro got=%b exp=101000", {bus.RO, bus.PG, bus.pos}); end
        bus.VE = 1'b1; step(1); bus.VE = 1'b0; step(1);
        checks++; if ({bus.selada, bus.erro} !== 2'b10) begin failures++; $display("FAIL seal_first got=%b exp=10", {bus.selada, bus.erro}); end
        bus.VE = 1'b1; step(1); bus.VE = 1'b0; step(3);
        checks++; if (bus.erro !== 1'b1) begin failures++; $display("FAIL seal_double got=%0d exp=1", bus.erro); end
    endtask

    task automatic test_exit();
        bus.MOTOR = 1'b1;
        step(4);
        checks++; if ({bus.CQ, bus.pos} !== 5'b1_1100) begin failures++; $display("FAIL exit_cq got=%b exp=11100", {bus.CQ, bus.pos}); end
        step(3);
        checks++; if ({bus.estado, bus.pos, bus.CQ} !== {ESTEIRA, 4'd15, 1'b0}) begin
            failures++; $display("FAIL exit_pos15 got=%b exp=%b", {bus.estado, bus.pos, bus.CQ}, {ESTEIRA, 4'd15, 1'b0}); end
        step(1);
        bus.MOTOR = 1'b0;
        checks++; if ({bus.estado, bus.IR} !== {SAIDA, 1'b1}) begin failures++; $display("FAIL exit_ir got=%b exp=111", {bus.estado, bus.IR}); end
        step(1);
        checks++; if ({bus.estado, bus.IR} !== {VAZIO, 1'b0}) begin failures++; $display("FAIL exit_ir_end got=%b exp=000", {bus.estado, bus.IR}); end
        checks++; if (bus.erro !== 1'b1) begin failures++; $display("FAIL exit_erro_sticky got=%0d exp=1", bus.erro); end
    endtask

    task automatic test_spill_alarm();
        step(3);
        checks++; if (bus.estoque !== 4'd10) begin failures++; $display("FAIL second_load got=%0d exp=10", bus.estoque); end
        do_reset();
        checks++; if ({bus.estado, bus.estoque, bus.erro} !== {VAZIO, 4'd12, 1'b0}) begin
            failures++; $display("FAIL midreset got=%b exp=%b", {bus.estado, bus.estoque, bus.erro}, {VAZIO, 4'd12, 1'b0}); end
        step(3);
        bus.MOTOR = 1'b1; bus.EV = 1'b1;
        step(2);
        bus.MOTOR = 1'b0;
        checks++; if ({bus.pos, bus.nivel, bus.erro} !== {4'd2, 3'd0, 1'b0}) begin
            failures++; $display("FAIL motor_ev got=%b exp=%b", {bus.pos, bus.nivel, bus.erro}, {4'd2, 3'd0, 1'b0}); end
        step(1);
        bus.EV = 1'b0;
        checks++; if ({bus.erro, bus.nivel} !== 4'b1000) begin failures++; $display("FAIL spill got=%b exp=1000", {bus.erro, bus.nivel}); end
        bus.ALARME = 1'b1; bus.MOTOR = 1'b1;
        step(4);
        bus.VE = 1'b1; step(1); bus.VE = 1'b0;
        step(5);
        checks++; if ({bus.estado, bus.pos, bus.selada} !== {ESTEIRA, 4'd2, 1'b0}) begin
            failures++; $display("FAIL alarm_freeze got=%b exp=%b", {bus.estado, bus.pos, bus.selada}, {ESTEIRA, 4'd2, 1'b0}); end
        bus.ALARME = 1'b0;
        step(1);
        checks++; if (bus.pos !== 4'd3) begin failures++; $display("FAIL alarm_release got=%0d exp=3", bus.pos); end
        bus.tick = 1'b0;
        step(3);
        bus.tick = 1'b1; bus.MOTOR = 1'b0;
        checks++; if (bus.pos !== 4'd3) begin failures++; $display("FAIL tick_gate got=%0d exp=3", bus.pos); end
    endtask

    task automatic test_magazine();
        int cyc = 0;
        int ir_count = 0;
        logic prev_ir = 1'b0;
        logic double_ir = 1'b0;
        do_reset();
        bus.MOTOR = 1'b1;
        while (ir_count < 12 && cyc < 400) begin
            step(1);
            cyc++;
            if (bus.IR === 1'b1) begin
                ir_count++;
                if (prev_ir) double_ir = 1'b1;
            end
            prev_ir = bus.IR;
        end
        checks++; if (ir_count != 12) begin failures++; $display("FAIL mag_bottles got=%0d exp=12", ir_count); end
        checks++; if (cyc != 239) begin failures++; $display("FAIL mag_cycles got=%0d exp=239", cyc); end
        checks++; if (double_ir !== 1'b0) begin failures++; $display("FAIL mag_ir_width got=%0d exp=0", double_ir); end
        step(5);
        checks++; if ({bus.estado, bus.EB, bus.estoque, bus.erro} !== {VAZIO, 1'b1, 4'd0, 1'b0}) begin
            failures++; $display("FAIL mag_empty got=%b exp=%b", {bus.estado, bus.EB, bus.estoque, bus.erro}, {VAZIO, 1'b1, 4'd0, 1'b0}); end
        bus.repor = 1'b1; step(1); bus.repor = 1'b0;
        checks++; if ({bus.EB, bus.estoque} !== {1'b0, 4'd12}) begin failures++; $display("FAIL repor got=%b exp=01100", {bus.EB, bus.estoque}); end
        step(3);
        checks++; if ({bus.estado, bus.estoque} !== {ESTEIRA, 4'd11}) begin
            failures++; $display("FAIL repor_load got=%b exp=%b", {bus.estado, bus.estoque}, {ESTEIRA, 4'd11}); end
        cyc = 0;
        while (bus.IR !== 1'b1 && cyc < 40) begin
            step(1);
            cyc++;
        end
        checks++; if (bus.IR !== 1'b1) begin failures++; $display("FAIL repor_exit_timeout got=%0d exp=1", bus.IR); end
        step(3);
        bus.repor = 1'b1; step(1); bus.repor = 1'b0;
        checks++; if ({bus.estado, bus.estoque} !== {ESTEIRA, 4'd11}) begin
            failures++; $display("FAIL repor_coincident got=%b exp=%b", {bus.estado, bus.estoque}, {ESTEIRA, 4'd11}); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_fill();
        test_seal();
        test_exit();
        test_spill_alarm();
        test_magazine();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
